pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 W_next_pc  in  32  next fetch address from the next-PC logic (sequential PC+4 or branch/jump target).
REQ-005 W_redirect  in  1  taken branch/jump; W_next_pc carries the target this cycle.
REQ-006 id_ready  in  1  decode stage accepts the fetched instruction this cycle.
REQ-007 imem_req  out  1  instruction-memory request valid.
REQ-008 imem_addr  out  32  request address; equals W_pc.
REQ-009 imem_gnt  in  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  in  1  read data valid for the oldest granted request.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 W_pc  out  32  address of the fetch being issued or outstanding; feeds the next-PC logic.
REQ-013 if_valid  out  1  fetch buffer holds an instruction for decode.
REQ-014 if_inst  out  32  buffered instruction.
REQ-015 if_pc  out  32  address of if_inst.
REQ-016 if_adel  out  1  buffered entry is a misaligned-fetch exception.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DROP; IDLE always goes to REQ on the next edge.
REQ-018 Fetch buffer holds one entry; consumption occurs on (if_valid && id_ready) and clears if_valid unless refilled that cycle.
REQ-019 In REQ with W_pc[1:0]==0: imem_req = (!if_valid || id_ready); (imem_req && imem_gnt) moves to WAIT.
REQ-020 In REQ with W_pc[1:0]!=0: imem_req=0; when the buffer is free, load if_valid=1, if_adel=1, if_inst=0, if_pc=W_pc; W_pc <= W_next_pc; remain in REQ.
REQ-021 In WAIT, imem_rvalid loads if_valid=1, if_adel=0, if_inst=imem_rdata, if_pc=W_pc; W_pc <= W_next_pc; state -> REQ (fetch-to-buffer latency is one cycle after rvalid).
REQ-022 Only one request outstanding; the buffer is guaranteed empty when a response is captured.
REQ-023 W_redirect has priority over all other events: if_valid <= 0, W_pc <= W_next_pc.
REQ-024 Redirect in REQ without grant, or in IDLE: state stays/goes REQ.
REQ-025 Redirect in REQ with same-cycle grant, or in WAIT without rvalid: state -> DROP.
REQ-026 Redirect in WAIT with same-cycle rvalid: response discarded, state -> REQ.
REQ-027 DROP: imem_req=0; imem_rvalid discards the data and moves to REQ; further redirects update W_pc only.
REQ-028 Responses arriving in IDLE or REQ are ignored.

Reset
REQ-029 rst_n low forces: state IDLE, W_pc=RESET_PC, if_valid=0, if_adel=0, if_inst=0, if_pc=0, imem_req=0.
REQ-030 Reset asserted mid-fetch abandons the outstanding request; the first response after release is only accepted via a new request.

Structure
REQ-031 FSM state encoding and RESET_PC default reside in the shared CPU package; the FSM is inline, no sub-module.
REQ-032 Implementation is a single module, target 120-400 lines.

Verification
REQ-033 Reset release, gnt same cycle, rvalid next cycle with 32'h2408_0001, id_ready=1, W_next_pc=W_pc+4 -> imem_addr 32'hBFC0_0000, then if_pc=32'hBFC0_0000, if_inst=32'h2408_0001, next imem_addr 32'hBFC0_0004.
REQ-034 id_ready=0 for 5 cycles with buffer full -> imem_req stays 0, if_inst stable; id_ready=1 -> imem_req asserted the same cycle.
REQ-035 Redirect to 32'hBFC0_0100 in WAIT, rvalid 2 cycles later -> that data never appears on if_inst; next imem_addr=32'hBFC0_0100.
REQ-036 Redirect with same-cycle rvalid -> if_valid stays 0, state REQ, next address is the target.
REQ-037 Redirect to 32'hBFC0_0102 -> no imem_req; if_valid=1, if_adel=1, if_pc=32'hBFC0_0102, if_inst=0.
REQ-038 rst_n low during WAIT -> all outputs at reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: fetch FSM state encoding and reset vector shared across the CPU.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch FSM with one outstanding memory request and a one-entry buffer.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] W_next_pc,
    input  logic        W_redirect,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] W_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_adel
);

    fetch_state_t state, state_nxt;
    logic free, aligned, fire, capture, adel_load, load;

    always_comb begin
        free      = !if_valid || id_ready;
        aligned   = W_pc[1:0] == 2'b00;
        imem_req  = (state == REQ) && aligned && free;
        fire      = imem_req && imem_gnt;
        capture   = (state == WAIT) && imem_rvalid && !W_redirect;
        adel_load = (state == REQ) && !aligned && free && !W_redirect;
        load      = capture || adel_load;
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  state_nxt = fire ? (W_redirect ? DROP : WAIT) : REQ;
            WAIT: state_nxt = imem_rvalid ? REQ : (W_redirect ? DROP : WAIT);
            DROP: state_nxt = imem_rvalid ? REQ : DROP;
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = W_pc;

    // A redirect squashes the buffer; in DROP it only retargets W_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            W_pc     <= RESET_PC;
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
            if_inst  <= 32'h0;
            if_pc    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (W_redirect || load)
                W_pc <= W_next_pc;
            if (W_redirect)
                if_valid <= 1'b0;
            else if (load) begin
                if_valid <= 1'b1;
                if_adel  <= adel_load;
                if_inst  <= capture ? imem_rdata : 32'h0;
                if_pc    <= W_pc;
            end else if (if_valid && id_ready)
                if_valid <= 1'b0;
        end
    end

endmodule
